// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard controller.
package pipe_pkg;

    // Control-transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        RESUME = 2'b10
    } pc_state_t;

    // E-stage ALU operand source selects.
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_W   = 2'b01;
    localparam fwd_sel_t FWD_M   = 2'b10;

endpackage : pipe_pkg

// File: rtl/fwd_unit.sv
// Forwarding compare for a single E-stage source operand; M beats W.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] write_reg_w,
    input  logic             reg_write_w,
    output fwd_sel_t         fwd_sel
);

    logic hit_m;
    logic hit_w;

    // Register 0 is hardwired to zero, so it is never forwarded.
    always_comb begin
        hit_m = reg_write_m && (write_reg_m != '0) && (write_reg_m == src);
        hit_w = reg_write_w && (write_reg_w != '0) && (write_reg_w == src);
        if (hit_m)      fwd_sel = FWD_M;
        else if (hit_w) fwd_sel = FWD_W;
        else            fwd_sel = FWD_REG;
    end

endmodule : fwd_unit

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS32 pipeline:
// load-use bubbles, E-stage forwarding selects, and control-transfer
// hold/resume sequencing with a wait timeout.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned REG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_xfer_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] write_reg_w,
    input  logic             reg_write_w,
    input  logic             resolved_e,
    input  logic             taken_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             resume,
    output logic             redirect,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_WAIT);

    pc_state_t        state;
    pc_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             taken_q;
    logic             taken_nxt;
    logic             timeout_hit;
    logic             resume_q;
    logic             redirect_q;
    logic             lu;
    fwd_sel_t         fwd_a_raw;
    fwd_sel_t         fwd_b_raw;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src         (rs_e),
        .write_reg_m (write_reg_m),
        .reg_write_m (reg_write_m),
        .write_reg_w (write_reg_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a_raw)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src         (rt_e),
        .write_reg_m (write_reg_m),
        .reg_write_m (reg_write_m),
        .write_reg_w (write_reg_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b_raw)
    );

    // Load in E whose destination is read by the instruction in D.
    always_comb begin
        lu = mem_to_reg_e && reg_write_e && (write_reg_e != '0) &&
             ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    end

    // Next-state logic; a resolution in the last WAIT cycle beats the timeout.
    always_comb begin
        state_nxt   = state;
        taken_nxt   = taken_q;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl_xfer_d && !lu) state_nxt = WAIT;
            end
            WAIT: begin
                if (resolved_e) begin
                    state_nxt = RESUME;
                    taken_nxt = taken_e;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RESUME;
                    taken_nxt   = 1'b0;
                    timeout_hit = 1'b1;
                end
            end
            RESUME: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, wait counter, latched outcome and registered resume pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            taken_q     <= 1'b0;
            resume_q    <= 1'b0;
            redirect_q  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            taken_q    <= taken_nxt;
            resume_q   <= (state_nxt == RESUME);
            redirect_q <= (state_nxt == RESUME) && taken_nxt;
            if (timeout_hit) timeout_err <= 1'b1;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pipeline control outputs; all forced low while reset is held.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        unique case (state)
            WAIT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end
            RESUME: flush_d = taken_q;
            default: ;
        endcase
        if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
        if (!rst) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end
    end

    // Forwarding selects, busy flag and registered pulse outputs.
    always_comb begin
        fwd_a_e  = rst ? fwd_a_raw : FWD_REG;
        fwd_b_e  = rst ? fwd_b_raw : FWD_REG;
        busy     = rst && (state != IDLE);
        resume   = resume_q;
        redirect = redirect_q;
    end

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MAX_WAIT=8, REG_W=5).
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic       ctrl_xfer_d;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, mem_to_reg_e, reg_write_m, reg_write_w;
    logic       resolved_e, taken_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       resume, redirect, busy, timeout_err;
    logic [1:0] fwd_a_e, fwd_b_e;

    int vectors;
    int miscompares;

    pipeline_ctrl #(.MAX_WAIT(8), .REG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_xfer_d  (ctrl_xfer_d),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .reg_write_e  (reg_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .write_reg_m  (write_reg_m),
        .reg_write_m  (reg_write_m),
        .write_reg_w  (write_reg_w),
        .reg_write_w  (reg_write_w),
        .resolved_e   (resolved_e),
        .taken_e      (taken_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .resume       (resume),
        .redirect     (redirect),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ctrl_xfer_d = 0; rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; mem_to_reg_e = 0; reg_write_m = 0; reg_write_w = 0;
        resolved_e = 0; taken_e = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall_f"}, {1'b0, stall_f}, 2'b00);
        chk({tag, ".stall_d"}, {1'b0, stall_d}, 2'b00);
        chk({tag, ".flush_d"}, {1'b0, flush_d}, 2'b00);
        chk({tag, ".flush_e"}, {1'b0, flush_e}, 2'b00);
        chk({tag, ".resume"}, {1'b0, resume}, 2'b00);
        chk({tag, ".redirect"}, {1'b0, redirect}, 2'b00);
        chk({tag, ".fwd_a"}, fwd_a_e, 2'b00);
        chk({tag, ".fwd_b"}, fwd_b_e, 2'b00);
        chk({tag, ".busy"}, {1'b0, busy}, 2'b00);
        chk({tag, ".timeout"}, {1'b0, timeout_err}, 2'b00);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        rst = 0;

        // Reset held with random inputs: everything low.
        for (int i = 0; i < 4; i++) begin
            ctrl_xfer_d = 1'($urandom); rs_d = 5'($urandom); rt_d = 5'($urandom);
            rs_e = 5'($urandom); rt_e = 5'($urandom);
            write_reg_e = rs_d; write_reg_m = rs_e; write_reg_w = rt_e;
            reg_write_e = 1; mem_to_reg_e = 1; reg_write_m = 1; reg_write_w = 1;
            resolved_e = 1'($urandom); taken_e = 1'($urandom);
            tick();
            chk_all_zero("rst_hold");
        end

        clear_inputs();
        rst = 1;
        tick();
        chk("rel.busy", {1'b0, busy}, 2'b00);
        chk("rel.timeout", {1'b0, timeout_err}, 2'b00);

        // Forwarding.
        rs_e = 5; rt_e = 3; write_reg_m = 5; reg_write_m = 1; write_reg_w = 5; reg_write_w = 1;
        #1;
        chk("fwd.a_m_over_w", fwd_a_e, 2'b10);
        chk("fwd.b_none", fwd_b_e, 2'b00);
        reg_write_m = 0;
        #1;
        chk("fwd.a_w", fwd_a_e, 2'b01);
        write_reg_w = 3;
        #1;
        chk("fwd.b_w", fwd_b_e, 2'b01);
        chk("fwd.a_after_w_move", fwd_a_e, 2'b00);
        rs_e = 0; rt_e = 0; write_reg_m = 0; write_reg_w = 0; reg_write_m = 1; reg_write_w = 1;
        #1;
        chk("fwd.a_r0", fwd_a_e, 2'b00);
        chk("fwd.b_r0", fwd_b_e, 2'b00);
        clear_inputs();

        // Load-use with a control transfer in D: bubble, stay IDLE.
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8; ctrl_xfer_d = 1;
        #1;
        chk("lu.stall_f", {1'b0, stall_f}, 2'b01);
        chk("lu.stall_d", {1'b0, stall_d}, 2'b01);
        chk("lu.flush_e", {1'b0, flush_e}, 2'b01);
        chk("lu.flush_d", {1'b0, flush_d}, 2'b00);
        tick();
        chk("lu.stay_idle", {1'b0, busy}, 2'b00);
        write_reg_e = 0;
        #1;
        chk("lu.cleared", {1'b0, stall_f}, 2'b00);
        tick();
        ctrl_xfer_d = 0;
        chk("lu.wait_busy", {1'b0, busy}, 2'b01);
        chk("lu.wait_stall_f", {1'b0, stall_f}, 2'b01);
        chk("lu.wait_flush_d", {1'b0, flush_d}, 2'b01);
        chk("lu.wait_stall_d", {1'b0, stall_d}, 2'b00);
        resolved_e = 1; taken_e = 0;
        tick();
        clear_inputs();
        chk("nt.resume", {1'b0, resume}, 2'b01);
        chk("nt.redirect", {1'b0, redirect}, 2'b00);
        chk("nt.flush_d", {1'b0, flush_d}, 2'b00);
        chk("nt.stall_f", {1'b0, stall_f}, 2'b00);
        tick();
        chk("nt.idle", {1'b0, busy}, 2'b00);
        chk("nt.resume_off", {1'b0, resume}, 2'b00);

        // Taken branch: ctrl at T, resolve at T+2.
        ctrl_xfer_d = 1;
        tick();                                   // T+1
        ctrl_xfer_d = 0;
        chk("tk.t1_stall_f", {1'b0, stall_f}, 2'b01);
        chk("tk.t1_flush_d", {1'b0, flush_d}, 2'b01);
        chk("tk.t1_busy", {1'b0, busy}, 2'b01);
        tick();                                   // T+2
        chk("tk.t2_stall_f", {1'b0, stall_f}, 2'b01);
        chk("tk.t2_flush_d", {1'b0, flush_d}, 2'b01);
        resolved_e = 1; taken_e = 1;
        tick();                                   // T+3
        resolved_e = 0; taken_e = 0;
        chk("tk.resume", {1'b0, resume}, 2'b01);
        chk("tk.redirect", {1'b0, redirect}, 2'b01);
        chk("tk.flush_d", {1'b0, flush_d}, 2'b01);
        chk("tk.stall_f", {1'b0, stall_f}, 2'b00);
        tick();                                   // T+4
        chk("tk.idle", {1'b0, busy}, 2'b00);
        chk("tk.redirect_off", {1'b0, redirect}, 2'b00);

        // Timeout: never resolved; forced resume 9 cycles after ctrl.
        ctrl_xfer_d = 1;
        tick();                                   // T+1
        ctrl_xfer_d = 0;
        for (int i = 1; i <= 8; i++) begin
            chk("to.wait_busy", {1'b0, busy}, 2'b01);
            chk("to.no_resume", {1'b0, resume}, 2'b00);
            chk("to.no_err_yet", {1'b0, timeout_err}, 2'b00);
            tick();
        end                                       // T+9
        chk("to.err", {1'b0, timeout_err}, 2'b01);
        chk("to.resume", {1'b0, resume}, 2'b01);
        chk("to.redirect", {1'b0, redirect}, 2'b00);
        chk("to.flush_d", {1'b0, flush_d}, 2'b00);
        tick();
        tick();
        chk("to.idle", {1'b0, busy}, 2'b00);
        chk("to.sticky", {1'b0, timeout_err}, 2'b01);

        // Asynchronous reset clears the sticky error.
        #2 rst = 0;
        #1;
        chk("rst2.timeout", {1'b0, timeout_err}, 2'b00);
        rst = 1;
        tick();

        // Resolution in the last WAIT cycle wins over the timeout.
        ctrl_xfer_d = 1;
        tick();                                   // T+1
        ctrl_xfer_d = 0;
        for (int i = 1; i <= 7; i++) begin
            chk("bd.wait_busy", {1'b0, busy}, 2'b01);
            tick();
        end                                       // T+8, counter at MAX_WAIT-1
        chk("bd.last_wait", {1'b0, resume}, 2'b00);
        resolved_e = 1; taken_e = 1;
        tick();                                   // T+9
        resolved_e = 0; taken_e = 0;
        chk("bd.resume", {1'b0, resume}, 2'b01);
        chk("bd.redirect", {1'b0, redirect}, 2'b01);
        chk("bd.no_err", {1'b0, timeout_err}, 2'b00);
        tick();
        chk("bd.idle", {1'b0, busy}, 2'b00);
        chk("bd.no_err_after", {1'b0, timeout_err}, 2'b00);

        // Reset mid-WAIT: immediate IDLE, no resume after release.
        ctrl_xfer_d = 1;
        tick();
        ctrl_xfer_d = 0;
        tick();
        chk("mw.busy", {1'b0, busy}, 2'b01);
        #2 rst = 0;
        #1;
        chk("mw.busy_rst", {1'b0, busy}, 2'b00);
        chk("mw.stall_rst", {1'b0, stall_f}, 2'b00);
        rst = 1;
        resolved_e = 1; taken_e = 1;
        tick();
        chk("mw.no_resume", {1'b0, resume}, 2'b00);
        chk("mw.no_redirect", {1'b0, redirect}, 2'b00);
        chk("mw.idle", {1'b0, busy}, 2'b00);
        resolved_e = 0; taken_e = 0;
        tick();
        chk("mw.no_resume2", {1'b0, resume}, 2'b00);
        chk("mw.no_err", {1'b0, timeout_err}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipeline_ctrl
